// File: rtl/serial_add_pkg.sv
// Shared constants for the serial adder: FSM state encoding and counter sizing.
package serial_add_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // A single-chunk unit still needs a 1-bit counter to keep the vector legal.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/serial_add_unit_chunk.sv
// CHUNK-bit combinational ripple adder slice used by serial_add_unit.
module add_chunk
  import serial_add_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] w_total;

  assign w_total = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign s       = w_total[CHUNK-1:0];
  assign co      = w_total[CHUNK];

endmodule

// File: rtl/serial_add_unit.sv
// Multi-cycle adder: CHUNK bits per cycle, LSB first, carry held between cycles.
// Optional signed-overflow output enabled by defining ADD_OVF_EN.
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (r_a_sh[CHUNK-1:0]),
    .y  (r_b_sh[CHUNK-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // New chunk enters at the MSB end so the first chunk lands at bit 0 after NCHUNK shifts.
  generate
    if (NCHUNK == 1) begin : g_single
      assign w_sum_next = w_s;
    end else begin : g_multi
      assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_carry <= w_co;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_sum   <= w_sum_next;
            r_cout  <= w_co;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a_sh <= a;
      r_b_sh <= b;
    end else if (r_state == CALC) begin
      r_a_sh   <= r_a_sh >> CHUNK;
      r_b_sh   <= r_b_sh >> CHUNK;
      r_sum_sh <= w_sum_next;
    end
  end

`ifdef ADD_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == CALC && r_cnt == LAST) begin
      r_ovf <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit (WIDTH=16, CHUNK=4); ADD_OVF_EN adds ovf checks.
module tb_serial_add_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef ADD_OVF_EN
  logic        ovf;
`endif

  int nvec = 0;
  int nerr = 0;

  serial_add_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] exp;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [16:0] res;
    logic        ov;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    exp_t e;
    e.res = {1'b0, xa} + {1'b0, xb} + {16'd0, xc};
    e.ov  = (xa[15] == xb[15]) && (e.res[15] != xa[15]);
    return e;
  endfunction

  // Waits for in_ready, presents one beat for exactly one accepting edge.
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = xa;
    b = xb;
    cin = xc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic [16:0] held;
    exp_t e;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, 1'b0};
    tbl[1] = '{16'h1234, 16'h4321, 1'b1, 17'h0_5556, 1'b0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 17'h0_0000, 1'b0};
    tbl[4] = '{16'h00FF, 16'h0001, 1'b0, 17'h0_0100, 1'b0};
    tbl[5] = '{16'h0FFF, 16'h0000, 1'b1, 17'h0_1000, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h0001, 1'b0, 17'h0_8000, 1'b1};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 17'h1_0000, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", {15'd0, cout, sum}, 32'd0);
`ifdef ADD_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].ci);
      wait_valid(lat);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd4);
      chk($sformatf("tbl%0d_result", i), {15'd0, cout, sum}, {15'd0, tbl[i].exp});
`ifdef ADD_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ov});
`endif
      take();
    end

    // Backpressure: result must hold while a new beat waits at the input.
    send(16'h1111, 16'h2222, 1'b0);
    wait_valid(lat);
    held = {cout, sum};
    chk("bp_first_result", {15'd0, held}, 32'h0000_3333);
    a = 16'h00FF;
    b = 16'h0F01;
    cin = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_result", {15'd0, cout, sum}, {15'd0, held});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_back_idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("bp_second_latency", lat, 32'd4);
    chk("bp_second_result", {15'd0, cout, sum}, 32'h0000_1001);
    take();

    // Reset asserted during the second CALC cycle.
    send(16'hABCD, 16'h1234, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0001, 16'h0001, 1'b0);
    wait_valid(lat);
    chk("midrst_after_result", {15'd0, cout, sum}, 32'h0000_0002);
    take();

    // Soak: random operands, random gaps, random out_ready stalls.
    fork
      begin : producer
        for (int i = 0; i < 100; i++) begin
          logic [15:0] ra;
          logic [15:0] rb;
          logic        rc;
          int          n;
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          n = 0;
          while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
          end
          if (!in_ready) begin
            chk("soak_in_ready_wait", {31'd0, in_ready}, 32'd1);
            break;
          end
          sb.push_back(model(ra, rb, rc));
          a = ra;
          b = rb;
          cin = rc;
          in_valid = 1'b1;
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin : consumer
        int got = 0;
        int cyc = 0;
        while (got < 100 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom);
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              chk("soak_duplicate", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("soak_result", {15'd0, cout, sum}, {15'd0, e.res});
`ifdef ADD_OVF_EN
              chk("soak_ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
            end
            got++;
          end
        end
        out_ready = 1'b0;
        chk("soak_count", got, 32'd100);
      end
    join
    chk("soak_leftover", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
